// File: rtl/bcd2bin_seq_if.sv
// bcd2bin_seq_if: start/done handshake and data bundle for bcd2bin_seq.
//   start   : conversion request (master -> slave)
//   bcd_in  : packed BCD word, digit 0 in [3:0] (master -> slave)
//   ready   : converter idle, start will be accepted (slave -> master)
//   busy    : conversion in progress (slave -> master)
//   done    : one-cycle result strobe (slave -> master)
//   err     : accepted word held a nibble > 9 (slave -> master)
//   bin_out : binary result, held until the next result (slave -> master)
interface bcd2bin_seq_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  ready;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [BIN_W-1:0]      bin_out;

  modport master (
    output start, bcd_in,
    input  ready, busy, done, err, bin_out
  );

  modport slave (
    input  start, bcd_in,
    output ready, busy, done, err, bin_out
  );
endinterface

// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: sequential BCD-to-binary converter (reverse double-dabble).
// One right shift per cycle followed by a parallel "-3 on every nibble >= 8"
// correction of the BCD field; BIN_W steps per conversion.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : bcd2bin_seq_if slave (start, bcd_in, ready, busy, done, err, bin_out)
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready; waits for start, validates digits on accept
// CONV  | one shift/correct step per cycle, BIN_W steps in total
// DONE  | one-cycle done strobe with bin_out/err valid
module bcd2bin_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic          clk,
  input  logic          rst,
  bcd2bin_seq_if.slave  bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int W_W   = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [W_W-1:0]     w_q, w_d;
  logic [W_W-1:0]     w_step;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic               err_q, err_d;
  logic               bad_digit;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.bcd_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  // A nibble >= 8 is exactly one whose top bit is set after the shift.
  always_comb begin
    w_step = w_q >> 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_step[BIN_W + 4*i + 3]) begin
        w_step[BIN_W + 4*i +: 4] = w_step[BIN_W + 4*i +: 4] - 4'd3;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    count_d = count_q;
    bin_d   = bin_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bad_digit) begin
            err_d   = 1'b1;
            bin_d   = '0;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            w_d     = {bus.bcd_in, {BIN_W{1'b0}}};
            count_d = '0;
            state_d = S_CONV;
          end
        end
      end
      S_CONV: begin
        w_d     = w_step;
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(BIN_W - 1)) begin
          bin_d   = w_step[BIN_W-1:0];
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      w_q     <= '0;
      count_q <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      count_q <= count_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

  assign bus.ready   = (state_q == S_IDLE);
  assign bus.busy    = (state_q == S_CONV);
  assign bus.done    = (state_q == S_DONE);
  assign bus.err     = err_q;
  assign bus.bin_out = bin_q;

endmodule
